vga_text_renderer: RTL and testbench

//  Character-cell renderer placed directly upstream of the 8x16 glyph ROM.
//  - Holds a TEXT_COLS x TEXT_ROWS buffer of 4-bit glyph codes, written by the matrix-compute side.
//  - Maps the VGA timing generator's pixel coordinates onto buffer cells.
//  - Drives glyph code/row/col to the ROM and turns the returned pixel into pipelined RGB plus delayed syncs.

---
 rtl/vga_text_renderer_if.sv | 37 +++
 rtl/vga_text_renderer.sv | 146 ++++++++++++++
 tb/tb_vga_text_renderer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_renderer_if.sv
// Signal bundle between the text renderer, the write side, the VGA timing generator and the glyph ROM.
interface vga_text_renderer_if;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [2:0]  wr_row;
  logic [3:0]  wr_code;
  logic        wr_ready;
  logic        busy;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [3:0]  glyph_code;
  logic [3:0]  glyph_row;
  logic [2:0]  glyph_col;
  logic        glyph_pixel;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;

  // master: environment (writer, timing generator, ROM); slave: the renderer
  modport master (
    output clear, wr_en, wr_col, wr_row, wr_code,
    output pix_x, pix_y, video_on, hsync_in, vsync_in, glyph_pixel,
    input  wr_ready, busy, glyph_code, glyph_row, glyph_col,
    input  rgb_out, hsync_out, vsync_out
  );

  modport slave (
    input  clear, wr_en, wr_col, wr_row, wr_code,
    input  pix_x, pix_y, video_on, hsync_in, vsync_in, glyph_pixel,
    output wr_ready, busy, glyph_code, glyph_row, glyph_col,
    output rgb_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/vga_text_renderer.sv
// Character-cell text renderer: glyph-code buffer with clear sweep, and a
// 2-stage pixel pipeline feeding the 8x16 glyph ROM and producing RGB + syncs.
module vga_text_renderer #(
  parameter int unsigned TEXT_COLS  = 16,
  parameter int unsigned TEXT_ROWS  = 8,
  parameter int unsigned ORIGIN_X   = 64,
  parameter int unsigned ORIGIN_Y   = 48,
  parameter logic [11:0] FG_RGB     = 12'hFFF,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter logic [3:0]  CODE_BLANK = 4'hF
) (
  input logic clk,
  input logic rst_n,
  vga_text_renderer_if.slave bus
);

  localparam int unsigned N        = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned ADDR_W   = $clog2(N);
  localparam int unsigned WIN_W    = 8 * TEXT_COLS;
  localparam int unsigned WIN_H    = 16 * TEXT_ROWS;
  localparam int unsigned CODE_MAX = 12;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic                busy_q;
  logic                wr_ready_q;
  logic [3:0]          mem [N];

  logic                wr_hit_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  logic [9:0]          dx_c;
  logic [9:0]          dy_c;
  logic                in_win_c;
  logic [ADDR_W-1:0]   rd_addr_c;

  logic [3:0]          glyph_code_q;
  logic [3:0]          glyph_row_q;
  logic [2:0]          glyph_col_q;
  logic                in_win_q;
  logic                hs1_q, vs1_q;
  logic [11:0]         rgb_q;
  logic                hs2_q, vs2_q;

  // Write decode: only in IDLE, dropped when a clear arrives the same cycle
  assign wr_hit_c  = (state == IDLE) && !bus.clear && bus.wr_en &&
                     (32'(bus.wr_col) < TEXT_COLS) && (32'(bus.wr_row) < TEXT_ROWS);
  assign wr_addr_c = ADDR_W'(bus.wr_row) * ADDR_W'(TEXT_COLS) + ADDR_W'(bus.wr_col);

  // Clear-sweep FSM; reset lands in CLEAR so the unreset buffer gets blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (bus.clear) begin
            clr_addr <= '0;
          end else if (clr_addr == ADDR_W'(N - 1)) begin
            state      <= IDLE;
            clr_addr   <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          state      <= CLEAR;
          clr_addr   <= '0;
          busy_q     <= 1'b1;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_addr] <= CODE_BLANK;
    else if (wr_hit_c)
      mem[wr_addr_c] <= bus.wr_code;
  end

  // Stage 1: window test and cell lookup from the current pixel coordinate
  assign dx_c      = bus.pix_x - 10'(ORIGIN_X);
  assign dy_c      = bus.pix_y - 10'(ORIGIN_Y);
  assign in_win_c  = bus.video_on &&
                     (32'(bus.pix_x) >= ORIGIN_X) && (32'(bus.pix_x) < ORIGIN_X + WIN_W) &&
                     (32'(bus.pix_y) >= ORIGIN_Y) && (32'(bus.pix_y) < ORIGIN_Y + WIN_H);
  assign rd_addr_c = ADDR_W'((dy_c >> 4) * 10'(TEXT_COLS) + (dx_c >> 3));

  // Read register doubles as glyph_code; read-first against a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_code_q <= '0;
      glyph_row_q  <= '0;
      glyph_col_q  <= '0;
      in_win_q     <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
    end else begin
      glyph_code_q <= mem[rd_addr_c];
      glyph_row_q  <= dy_c[3:0];
      glyph_col_q  <= 3'd7 - dx_c[2:0];
      in_win_q     <= in_win_c;
      hs1_q        <= bus.hsync_in;
      vs1_q        <= bus.vsync_in;
    end
  end

  // Stage 2: colour from ROM pixel; codes above 12 render as background
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= BG_RGB;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= (in_win_q && (glyph_code_q <= 4'(CODE_MAX)) && bus.glyph_pixel) ? FG_RGB : BG_RGB;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.glyph_code = glyph_code_q;
  assign bus.glyph_row  = glyph_row_q;
  assign bus.glyph_col  = glyph_col_q;
  assign bus.rgb_out    = rgb_q;
  assign bus.hsync_out  = hs2_q;
  assign bus.vsync_out  = vs2_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: ROM stand-in, cell-level reference model and directed/random steps.
module tb_vga_text_renderer;

  localparam int OX   = 64;
  localparam int OY   = 48;
  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int N    = COLS * ROWS;

  logic clk;
  logic rst_n;

  vga_text_renderer_if vif();

  vga_text_renderer dut (.clk(clk), .rst_n(rst_n), .bus(vif));

  int n_cmp = 0;
  int n_bad = 0;

  int cells [N];
  int sweep_pos;
  logic [14:0] exp_q [$];   // {known, rgb[11:0], hsync, vsync}

  always #5 clk = ~clk;

  // Arbitrary glyph ROM contents, except '7' row 2 which is the documented 8'hFE
  function automatic logic [7:0] rom_byte(input int code, input int row);
    if (code == 7 && row == 2) return 8'hFE;
    return 8'(code * 37 + row * 11) ^ 8'h5A;
  endfunction

  function automatic logic rom_pix(input logic [3:0] code, input logic [3:0] row, input logic [2:0] col);
    logic [7:0] r;
    r = rom_byte(int'(code), int'(row));
    return r[col];
  endfunction

  assign vif.glyph_pixel = rom_pix(vif.glyph_code, vif.glyph_row, vif.glyph_col);

  function automatic void ref_rgb(input int x, input int y, input bit von,
                                  output logic [11:0] e, output bit known);
    int c;
    logic [7:0] r;
    known = 1'b1;
    e = 12'h000;
    if (von && x >= OX && x < OX + 8 * COLS && y >= OY && y < OY + 16 * ROWS) begin
      c = cells[((y - OY) / 16) * COLS + (x - OX) / 8];
      if (c < 0) known = 1'b0;
      else if (c <= 12) begin
        r = rom_byte(c, (y - OY) % 16);
        if (r[7 - (x - OX) % 8]) e = 12'hFFF;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from current inputs, update the cell model, clock, then check
  task automatic tick();
    logic [11:0] e;
    bit known;
    logic [14:0] s;
    ref_rgb(int'(vif.pix_x), int'(vif.pix_y), vif.video_on, e, known);
    exp_q.push_back({known, e, vif.hsync_in, vif.vsync_in});
    if (sweep_pos >= 0) begin
      cells[sweep_pos] = 15;
      if (vif.clear) sweep_pos = 0;
      else if (sweep_pos == N - 1) sweep_pos = -1;
      else sweep_pos++;
    end else if (vif.clear) begin
      sweep_pos = 0;
    end else if (vif.wr_en && int'(vif.wr_col) < COLS && int'(vif.wr_row) < ROWS) begin
      cells[int'(vif.wr_row) * COLS + int'(vif.wr_col)] = int'(vif.wr_code);
    end
    @(posedge clk);
    #1;
    s = exp_q.pop_front();
    if (s[14]) chk("rgb_out", 32'(vif.rgb_out), 32'(s[13:2]));
    chk("hsync_out", 32'(vif.hsync_out), 32'(s[1]));
    chk("vsync_out", 32'(vif.vsync_out), 32'(s[0]));
    chk("busy", 32'(vif.busy), 32'(sweep_pos >= 0));
    chk("wr_ready", 32'(vif.wr_ready), 32'(sweep_pos < 0));
  endtask

  task automatic model_reset();
    sweep_pos = 0;
    exp_q.delete();
    exp_q.push_back({1'b1, 12'h000, 1'b1, 1'b1});
  endtask

  task automatic set_pix(input int x, input int y, input bit von);
    vif.pix_x    = 10'(x);
    vif.pix_y    = 10'(y);
    vif.video_on = von;
  endtask

  task automatic do_write(input int col, input int row, input int code);
    vif.wr_en   = 1'b1;
    vif.wr_col  = 4'(col);
    vif.wr_row  = 3'(row);
    vif.wr_code = 4'(code);
    tick();
    vif.wr_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"},   32'(vif.rgb_out),    32'h000);
    chk({tag, "_hs"},    32'(vif.hsync_out),  32'd1);
    chk({tag, "_vs"},    32'(vif.vsync_out),  32'd1);
    chk({tag, "_busy"},  32'(vif.busy),       32'd1);
    chk({tag, "_wrrdy"}, 32'(vif.wr_ready),   32'd0);
    chk({tag, "_gcode"}, 32'(vif.glyph_code), 32'd0);
    chk({tag, "_grow"},  32'(vif.glyph_row),  32'd0);
    chk({tag, "_gcol"},  32'(vif.glyph_col),  32'd0);
  endtask

  initial begin
    int cnt;
    clk = 1'b0;
    rst_n = 1'b1;
    vif.clear = 1'b0; vif.wr_en = 1'b0; vif.wr_col = '0; vif.wr_row = '0; vif.wr_code = '0;
    vif.pix_x = '0; vif.pix_y = '0; vif.video_on = 1'b0; vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    for (int i = 0; i < N; i++) cells[i] = -1;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    #4 rst_n = 1'b1;
    model_reset();

    // Post-reset sweep: exactly N busy cycles
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!vif.busy) break;
      cnt++;
      tick();
    end
    chk("reset_busy_len", 32'(cnt), 32'd128);

    // Whole window blank
    for (int i = 0; i < 40; i++) begin
      set_pix(OX + $urandom_range(0, 8 * COLS - 1), OY + $urandom_range(0, 16 * ROWS - 1), 1'b1);
      tick();
    end

    // Digit 7 at (0,0), row 2 scanned left to right
    set_pix(0, 0, 1'b0);
    do_write(0, 0, 7);
    for (int k = 0; k < 8; k++) begin
      set_pix(OX + k, OY + 2, 1'b1);
      tick();
    end

    // Code 13 at (1,0): background everywhere, code still presented to ROM
    do_write(1, 0, 13);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 8; k++) begin
        set_pix(OX + 8 + k, OY + r, 1'b1);
        tick();
        chk("glyph_code13", 32'(vif.glyph_code), 32'd13);
      end

    // Just left of the window, and video_on low over a lit pixel
    set_pix(OX - 1, OY + 2, 1'b1); tick();
    set_pix(OX, OY + 2, 1'b0);     tick();
    set_pix(OX, OY + 2, 1'b1);     tick();
    tick();

    // Random writes, pixels and syncs
    for (int i = 0; i < 600; i++) begin
      vif.wr_en    = ($urandom_range(0, 3) == 0);
      vif.wr_col   = 4'($urandom_range(0, 15));
      vif.wr_row   = 3'($urandom_range(0, 7));
      vif.wr_code  = 4'($urandom_range(0, 15));
      vif.hsync_in = 1'($urandom_range(0, 1));
      vif.vsync_in = 1'($urandom_range(0, 1));
      if (i % 2 == 0)
        set_pix(OX + 8 * int'(vif.wr_col) + $urandom_range(0, 7),
                OY + 16 * int'(vif.wr_row) + $urandom_range(0, 15), 1'($urandom_range(0, 4) != 0));
      else
        set_pix(OX - 8 + $urandom_range(0, 8 * COLS + 15),
                OY - 8 + $urandom_range(0, 16 * ROWS + 15), 1'($urandom_range(0, 4) != 0));
      tick();
    end
    vif.wr_en = 1'b0;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;

    // Clear with a simultaneous write: write dropped, pixels of (2,2) watched during the sweep
    do_write(2, 2, 8);
    vif.clear = 1'b1;
    vif.wr_en = 1'b1; vif.wr_col = 4'd2; vif.wr_row = 3'd2; vif.wr_code = 4'd5;
    tick();
    vif.clear = 1'b0; vif.wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!vif.busy) break;
      cnt++;
      set_pix(OX + 16 + (i % 8), OY + 32 + (i % 16), 1'b1);
      tick();
    end
    chk("clear_busy_len", 32'(cnt), 32'd128);
    for (int i = 0; i < 10; i++) begin
      set_pix(OX + 16 + (i % 8), OY + 32 + i, 1'b1);
      tick();
    end

    // Sweep restarted by a second clear on its 50th cycle
    vif.clear = 1'b1;
    tick();
    vif.clear = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!vif.busy) break;
      cnt++;
      vif.clear = (cnt == 50);
      tick();
    end
    vif.clear = 1'b0;
    chk("restart_busy_len", 32'(cnt), 32'd178);

    // Sync toggling
    for (int i = 0; i < 12; i++) begin
      vif.hsync_in = 1'(i % 2);
      vif.vsync_in = 1'((i / 3) % 2);
      tick();
    end

    // Lit pixel with syncs low, then asynchronous reset mid-cycle
    do_write(0, 0, 7);
    set_pix(OX + 1, OY + 2, 1'b1);
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;
    repeat (3) tick();
    chk("pre_reset_rgb", 32'(vif.rgb_out), 32'hFFF);
    chk("pre_reset_hs", 32'(vif.hsync_out), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    #3 rst_n = 1'b1;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    set_pix(0, 0, 1'b0);
    model_reset();
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!vif.busy) break;
      cnt++;
      tick();
    end
    chk("rereset_busy_len", 32'(cnt), 32'd128);
    for (int i = 0; i < 20; i++) begin
      set_pix(OX + $urandom_range(0, 8 * COLS - 1), OY + $urandom_range(0, 16 * ROWS - 1), 1'b1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
